// File: rtl/renorm_arbiter.sv
// renorm_arbiter: two-lane arbiter and sequencer for the shared AV1 encoder
// renormalization unit. It grants one lane per cycle, normalizes range/low,
// updates s and releases the high byte of low. The result sits in a
// one-entry output register tagged with the lane.
// Optional build macro: RENORM_ARB_FIXED_PRIO_EN (lane 0 always wins ties).
module renorm_arbiter #(
  parameter int unsigned RANGE_WIDTH = 16,
  parameter int unsigned LOW_WIDTH   = 24,
  parameter int unsigned D_SIZE      = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid_0,
  input  logic                             req_valid_1,
  output logic                             req_ready_0,
  output logic                             req_ready_1,
  input  logic [RANGE_WIDTH-1:0]           req_range_0,
  input  logic [RANGE_WIDTH-1:0]           req_range_1,
  input  logic [LOW_WIDTH-1:0]             req_low_0,
  input  logic [LOW_WIDTH-1:0]             req_low_1,
  input  logic [D_SIZE-1:0]                req_s_0,
  input  logic [D_SIZE-1:0]                req_s_1,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_lane,
  output logic [RANGE_WIDTH-1:0]           out_range,
  output logic [LOW_WIDTH-1:0]             out_low,
  output logic [D_SIZE-1:0]                out_s,
  output logic                             out_release,
  output logic [LOW_WIDTH-RANGE_WIDTH-1:0] out_chunk,
  output logic                             out_err
);

  localparam int unsigned ChunkW = LOW_WIDTH - RANGE_WIDTH;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e state_q, state_d;

  logic can_grant, grant_0, grant_1, grant_any;

  logic                   lane_q;
  logic [RANGE_WIDTH-1:0] range_q;
  logic [LOW_WIDTH-1:0]   low_q;
  logic [D_SIZE-1:0]      s_q;
  logic                   release_q;
  logic [ChunkW-1:0]      chunk_q;
  logic                   err_q;

  logic [RANGE_WIDTH-1:0] sel_range, range1, res_range;
  logic [LOW_WIDTH-1:0]   sel_low, low1, res_low;
  logic [D_SIZE-1:0]      sel_s, d, s1, res_s;
  logic                   res_release, res_err;
  logic [ChunkW-1:0]      res_chunk;

  // Leading-zero count; the result for an all-zero input is never used.
  function automatic logic [D_SIZE-1:0] lzc(input logic [RANGE_WIDTH-1:0] v);
    logic [D_SIZE-1:0] n;
    logic              found;
    n     = '0;
    found = 1'b0;
    for (int i = RANGE_WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + D_SIZE'(1);
      end
    end
    return n;
  endfunction

  // A new result can be taken when the register is empty or being drained.
  assign can_grant = (state_q == StEmpty) || out_ready;

`ifdef RENORM_ARB_FIXED_PRIO_EN
  // Fixed priority: lane 0 wins every tie.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (!reset && can_grant) begin
      grant_0 = req_valid_0;
      grant_1 = req_valid_1 && !req_valid_0;
    end
  end
`else
  logic prio_q, prio_d;

  // Round-robin: a tie goes to the lane named by prio.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (!reset && can_grant) begin
      grant_0 = req_valid_0 && (!req_valid_1 || !prio_q);
      grant_1 = req_valid_1 && (!req_valid_0 || prio_q);
    end
  end

  // After a grant to lane k the other lane gets the next tie.
  always_comb begin
    prio_d = prio_q;
    if (grant_0)      prio_d = 1'b1;
    else if (grant_1) prio_d = 1'b0;
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end
`endif

  assign grant_any   = grant_0 || grant_1;
  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  // Renormalize the granted request: shift, counter update, byte release.
  always_comb begin
    sel_range   = grant_1 ? req_range_1 : req_range_0;
    sel_low     = grant_1 ? req_low_1   : req_low_0;
    sel_s       = grant_1 ? req_s_1     : req_s_0;
    d           = lzc(sel_range);
    s1          = sel_s + d;
    low1        = sel_low << d;
    range1      = sel_range << d;
    res_range   = sel_range;
    res_low     = sel_low;
    res_s       = sel_s;
    res_release = 1'b0;
    res_chunk   = '0;
    res_err     = 1'b0;
    if (sel_range == '0) begin
      res_err = 1'b1;
    end else if (s1 >= D_SIZE'(9)) begin
      res_range   = range1;
      res_s       = s1 - D_SIZE'(8);
      res_chunk   = low1[LOW_WIDTH-1:RANGE_WIDTH];
      res_low     = low1 & {{ChunkW{1'b0}}, {RANGE_WIDTH{1'b1}}};
      res_release = 1'b1;
    end else begin
      res_range = range1;
      res_s     = s1;
      res_low   = low1;
    end
  end

  // Output register occupancy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (grant_any) state_d = StFull;
      StFull:  if (out_ready) state_d = grant_any ? StFull : StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // State register; reset discards any pending result.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StEmpty;
    else       state_q <= state_d;
  end

  // Result register loads on every grant and otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q    <= 1'b0;
      range_q   <= '0;
      low_q     <= '0;
      s_q       <= '0;
      release_q <= 1'b0;
      chunk_q   <= '0;
      err_q     <= 1'b0;
    end else if (grant_any) begin
      lane_q    <= grant_1;
      range_q   <= res_range;
      low_q     <= res_low;
      s_q       <= res_s;
      release_q <= res_release;
      chunk_q   <= res_chunk;
      err_q     <= res_err;
    end
  end

  assign out_valid   = (state_q == StFull);
  assign out_lane    = lane_q;
  assign out_range   = range_q;
  assign out_low     = low_q;
  assign out_s       = s_q;
  assign out_release = release_q;
  assign out_chunk   = chunk_q;
  assign out_err     = err_q;

endmodule

// File: tb/tb_renorm_arbiter.sv
// Directed testbench for renorm_arbiter with hand-computed expectations.
module tb_renorm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [15:0] req_range_0, req_range_1;
  logic [23:0] req_low_0, req_low_1;
  logic [4:0]  req_s_0, req_s_1;
  logic        out_valid, out_ready, out_lane, out_release, out_err;
  logic [15:0] out_range;
  logic [23:0] out_low;
  logic [4:0]  out_s;
  logic [7:0]  out_chunk;

  int n_cmp = 0;
  int n_err = 0;

  renorm_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_0 (req_valid_0),
    .req_valid_1 (req_valid_1),
    .req_ready_0 (req_ready_0),
    .req_ready_1 (req_ready_1),
    .req_range_0 (req_range_0),
    .req_range_1 (req_range_1),
    .req_low_0   (req_low_0),
    .req_low_1   (req_low_1),
    .req_s_0     (req_s_0),
    .req_s_1     (req_s_1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_lane    (out_lane),
    .out_range   (out_range),
    .out_low     (out_low),
    .out_s       (out_s),
    .out_release (out_release),
    .out_chunk   (out_chunk),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_lane [4];
`ifdef RENORM_ARB_FIXED_PRIO_EN
    exp_lane = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_lane = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
    reset = 1'b1;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    req_range_0 = '0; req_range_1 = '0;
    req_low_0 = '0; req_low_1 = '0;
    req_s_0 = '0; req_s_1 = '0;
    out_ready = 1'b1;
    step();
    step();
    check("rst_ready0", 32'(req_ready_0), 0);
    check("rst_ready1", 32'(req_ready_1), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_range", 32'(out_range), 0);
    check("rst_low", 32'(out_low), 0);
    check("rst_s", 32'(out_s), 0);
    check("rst_err", 32'(out_err), 0);
    reset = 1'b0;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;

    // Lane 0 normalization with release.
    req_valid_0 = 1'b1; req_range_0 = 16'h0123; req_low_0 = 24'h000ABC; req_s_0 = 5'd2;
    #1;
    check("t1_ready0", 32'(req_ready_0), 1);
    check("t1_ready1", 32'(req_ready_1), 0);
    step();
    req_valid_0 = 1'b0;
    check("t1_valid", 32'(out_valid), 1);
    check("t1_lane", 32'(out_lane), 0);
    check("t1_range", 32'(out_range), 32'h9180);
    check("t1_s", 32'(out_s), 1);
    check("t1_rel", 32'(out_release), 1);
    check("t1_chunk", 32'(out_chunk), 32'h05);
    check("t1_low", 32'(out_low), 32'h005E00);

    // Lane 1, already normalized.
    req_valid_1 = 1'b1; req_range_1 = 16'h8000; req_low_1 = 24'h123456; req_s_1 = 5'd3;
    step();
    req_valid_1 = 1'b0;
    check("t2_lane", 32'(out_lane), 1);
    check("t2_range", 32'(out_range), 32'h8000);
    check("t2_low", 32'(out_low), 32'h123456);
    check("t2_s", 32'(out_s), 3);
    check("t2_rel", 32'(out_release), 0);
    check("t2_chunk", 32'(out_chunk), 0);
    step();
    check("drain_valid", 32'(out_valid), 0);

    // Both lanes contend for 4 cycles.
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    req_range_0 = 16'h8000; req_range_1 = 16'h8000;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_ready0_%0d", i), 32'(req_ready_0), 32'(exp_lane[i] == 2'd0));
      check($sformatf("rr_ready1_%0d", i), 32'(req_ready_1), 32'(exp_lane[i] == 2'd1));
      step();
      check($sformatf("rr_lane_%0d", i), 32'(out_lane), 32'(exp_lane[i]));
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    step();
    check("rr_drain", 32'(out_valid), 0);

    // Backpressure hold.
    req_valid_0 = 1'b1; req_range_0 = 16'h4000; req_low_0 = 24'h123456; req_s_0 = 5'd8;
    step();
    req_range_0 = 16'h8000; req_low_0 = 24'h000001; req_s_0 = 5'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_ready0_%0d", i), 32'(req_ready_0), 0);
      check($sformatf("bp_ready1_%0d", i), 32'(req_ready_1), 0);
      check($sformatf("bp_valid_%0d", i), 32'(out_valid), 1);
      check($sformatf("bp_range_%0d", i), 32'(out_range), 32'h8000);
      check($sformatf("bp_low_%0d", i), 32'(out_low), 32'h0068AC);
      check($sformatf("bp_chunk_%0d", i), 32'(out_chunk), 32'h24);
      check($sformatf("bp_s_%0d", i), 32'(out_s), 1);
      check($sformatf("bp_rel_%0d", i), 32'(out_release), 1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_ready0", 32'(req_ready_0), 1);
    step();
    check("bp2_range", 32'(out_range), 32'h8000);
    check("bp2_low", 32'(out_low), 32'h000001);
    check("bp2_s", 32'(out_s), 0);
    check("bp2_rel", 32'(out_release), 0);

    // Zero range from lane 0: passes through with error flag.
    req_range_0 = 16'h0000; req_low_0 = 24'h00FFFF; req_s_0 = 5'd4;
    step();
    req_valid_0 = 1'b0;
    check("z_err", 32'(out_err), 1);
    check("z_range", 32'(out_range), 0);
    check("z_low", 32'(out_low), 32'h00FFFF);
    check("z_s", 32'(out_s), 4);
    check("z_rel", 32'(out_release), 0);
    check("z_lane", 32'(out_lane), 0);

    // Reset pulse while full and both lanes request; prio was left at 1.
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    req_range_0 = 16'h8000; req_range_1 = 16'h8000;
    reset = 1'b1;
    #1;
    check("mr_ready0", 32'(req_ready_0), 0);
    check("mr_ready1", 32'(req_ready_1), 0);
    step();
    check("mr_valid", 32'(out_valid), 0);
    check("mr_err", 32'(out_err), 0);
    reset = 1'b0;
    #1;
    check("mr_first_ready0", 32'(req_ready_0), 1);
    check("mr_first_ready1", 32'(req_ready_1), 0);
    step();
    check("mr_first_lane", 32'(out_lane), 0);
    check("mr_first_valid", 32'(out_valid), 1);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
